mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates the single unified instruction/data memory of the pipelined MIPS32 core between three requesters:
  - IF stage: instruction fetch, read-only.
  - MEM stage: LW/SW data access.
  - Debug/loader port: memory init before run and inspection after HALT.
- Sequences each access through an issue/wait/response FSM with configurable memory latency.
- Prevents IF starvation under sustained data traffic.

Parameters:
- ADDR_W, 10, word-address width (1024-word memory).
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from mem_en cycle to mem_rdata valid; legal range 1..4.
- STARVE_MAX, 4, consecutive DM grants allowed while if_req is pending before IF is forced.

Ports:
- clk1  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch word address.
- if_ack  out  1  one-cycle completion pulse.
- if_rdata  out  DATA_W  fetched word; valid with if_ack, held until next if_ack.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1 = store (SW), 0 = load (LW).
- dm_addr  in  ADDR_W  data word address.
- dm_wdata  in  DATA_W  store data.
- dm_ack  out  1  completion pulse.
- dm_rdata  out  DATA_W  load data; valid with dm_ack, held until next dm_ack.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug access; same rules as dm_*.
- dbg_ack  out  1  completion pulse.
- dbg_rdata  out  DATA_W  debug read data.
- mem_en  out  1  memory access strobe, exactly one cycle per transaction.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data.
- owner  out  2  port currently served: 0 = IF, 1 = DM, 2 = DBG, 3 = none.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Clock/reset: one clock (clk1); synchronous active-high reset.
- Reset values:
  - FSM = IDLE.
  - All acks, mem_en, mem_we = 0.
  - mem_addr, mem_wdata, all *_rdata = 0.
  - owner = 3; starvation counter = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high at the clock edge: latch the winner's we/addr/wdata into mem_* registers, set owner, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: mem_en = 1 for exactly this cycle; load wait counter with MEM_LAT; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the final WAIT cycle (counter = 1), mem_rdata is valid; on that edge, capture it into the owner's *_rdata (reads only) and go to RESP.
- RESP: owner's ack = 1 for this cycle only; go to IDLE; owner returns to 3.
- Latency: req seen in cycle 0 gives ack in cycle MEM_LAT+2 (cycle 3 for MEM_LAT = 1). Writes have identical timing; *_rdata is unchanged on writes.
- Requester rule: req and its address/data are held stable until ack; req is deasserted the cycle after ack. Because RESP always passes through IDLE, the just-acked port is never re-granted on a stale req.
- Priority: DBG > DM > IF.
- Starvation override:
  - The counter increments on each DM grant made while if_req is high.
  - When the counter equals STARVE_MAX, the next arbitration with both DM and IF pending grants IF.
  - Any IF grant clears the counter.
  - DBG still preempts the override.
- Requests arriving during ISSUE/WAIT/RESP are not sampled; they are arbitrated in the next IDLE cycle.
- Simultaneous requests from all three ports are served in priority order: DBG first, DM second, IF last (subject to the override).
- Reset mid-transaction: FSM aborts to IDLE, no ack is issued, *_rdata is cleared. A write already strobed in ISSUE may have committed; requesters must reissue after reset.
- Address wrap: no range checking; the address passes through modulo 2^ADDR_W.

Decomposition:
- Shared package mips32_mem_pkg:
  - FSM state encoding.
  - Port ID constants PORT_IF = 0, PORT_DM = 1, PORT_DBG = 2, PORT_NONE = 3.
  - MEM_LAT legal-range constants.
- One sub-module, mem_arb_pick: combinational priority picker. Inputs: three reqs and the starvation-force flag. Output: 2-bit winner.
- FSM, counters and registers stay in mem_port_arbiter.

Test Plan:
1. MEM_LAT = 1, memory word 0 = 32'h28010078; if_req with addr 0 in cycle 0 -> mem_en in cycle 1, if_ack in cycle 3, if_rdata = 32'h28010078.
2. DBG write addr 120 = 85, then DM load addr 120 and DM store addr 121 = 130 -> dm_rdata = 85; subsequent DBG read of 121 returns 130; dm_rdata unchanged by the store.
3. if_req and dm_req rise together -> DM acked in cycle 3, IF granted in the following IDLE, if_ack in cycle 7; owner sequence 1, 3, 0.
4. dm_req held continuously with back-to-back requests, if_req held, STARVE_MAX = 4 -> exactly 4 DM grants, then 1 IF grant, then DM resumes; counter = 0 after the IF grant.
5. All three reqs asserted in cycle 0 -> grant order DBG, DM, IF; one ack each, never two acks in one cycle.
6. MEM_LAT = 3, reset pulsed in the second WAIT cycle -> no ack, busy = 0 and owner = 3 the cycle after reset; a reissued request completes with ack at cycle 5 relative to its req.

Source files
------------

// File: rtl/mips32_mem_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
//   - arb_state_e     : arbiter FSM state encoding
//   - PORT_*          : requester identifiers carried on the owner output
//   - MEM_LAT_MIN/MAX : supported range of memory read latency (cycles)
package mips32_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic [1:0] PORT_IF   = 2'd0;
    localparam logic [1:0] PORT_DM   = 2'd1;
    localparam logic [1:0] PORT_DBG  = 2'd2;
    localparam logic [1:0] PORT_NONE = 2'd3;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority picker for the memory arbiter.
// Ports:
//   if_req, dm_req, dbg_req : pending requests from fetch, data and debug ports
//   force_if                : starvation override, lets IF jump ahead of DM
//   winner                  : selected port (PORT_IF/DM/DBG, PORT_NONE if idle)
module mem_arb_pick
    import mips32_mem_pkg::*;
(
    input  logic       if_req,
    input  logic       dm_req,
    input  logic       dbg_req,
    input  logic       force_if,
    output logic [1:0] winner
);

    // Debug always wins; the starvation override only reorders IF against DM.
    always_comb begin
        winner = PORT_NONE;
        if (dbg_req) begin
            winner = PORT_DBG;
        end else if (force_if && if_req) begin
            winner = PORT_IF;
        end else if (dm_req) begin
            winner = PORT_DM;
        end else if (if_req) begin
            winner = PORT_IF;
        end else begin
            winner = PORT_NONE;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single unified memory of the pipelined MIPS32 core.
// Serves instruction fetch (IF), data access (DM) and debug/loader (DBG)
// one transaction at a time through IDLE -> ISSUE -> WAIT -> RESP.
// Ports:
//   clk1, reset                       : clock, synchronous active-high reset
//   if_req/if_addr -> if_ack/if_rdata : read-only fetch port
//   dm_*  / dbg_*                     : read/write ports (we, addr, wdata in; ack, rdata out)
//   mem_en/mem_we/mem_addr/mem_wdata  : registered memory command, mem_en one cycle per access
//   mem_rdata                         : memory read data, valid MEM_LAT cycles after mem_en
//   owner                             : port being served (3 = none)
//   busy                              : high whenever the FSM is out of IDLE
module mem_port_arbiter
    import mips32_mem_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner,
    output logic              busy
);

    // Out-of-range latencies are clamped so the wait counter always terminates.
    localparam int LAT_EFF = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                             (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [2:0]      LAT_LOAD   = 3'(LAT_EFF);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic [2:0]        lat_cnt_r;
    logic [SC_W-1:0]   starve_cnt_r;
    logic [1:0]        owner_r;
    logic [1:0]        winner_s;
    logic              force_if_s;
    logic              grant_s;
    logic              done_s;
    logic              txn_we_r;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              if_ack_r;
    logic              dm_ack_r;
    logic              dbg_ack_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] dm_rdata_r;
    logic [DATA_W-1:0] dbg_rdata_r;
    logic              busy_r;

    assign force_if_s = (starve_cnt_r == STARVE_LIM);
    // Requests are only sampled in IDLE; anything arriving later waits its turn.
    assign grant_s    = (state_r == ST_IDLE) && (winner_s != PORT_NONE);
    // Last WAIT cycle: mem_rdata is valid now.
    assign done_s     = (state_r == ST_WAIT) && (lat_cnt_r == 3'd1);

    mem_arb_pick u_pick (
        .if_req   (if_req),
        .dm_req   (dm_req),
        .dbg_req  (dbg_req),
        .force_if (force_if_s),
        .winner   (winner_s)
    );

    // Route the winning port's command fields toward the memory registers.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        case (winner_s)
            PORT_DBG: begin
                sel_we_s    = dbg_we;
                sel_addr_s  = dbg_addr;
                sel_wdata_s = dbg_wdata;
            end
            PORT_DM: begin
                sel_we_s    = dm_we;
                sel_addr_s  = dm_addr;
                sel_wdata_s = dm_wdata;
            end
            PORT_IF: begin
                sel_we_s    = 1'b0;
                sel_addr_s  = if_addr;
                sel_wdata_s = {DATA_W{1'b0}};
            end
            default: begin
                sel_we_s    = 1'b0;
                sel_addr_s  = {ADDR_W{1'b0}};
                sel_wdata_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // FSM next-state logic; RESP always returns through IDLE so a stale req is never re-granted.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (done_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk1) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Command capture at grant, single-cycle mem strobe, wait countdown and busy flag.
    always_ff @(posedge clk1) begin
        if (reset) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            txn_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            lat_cnt_r   <= 3'd0;
            busy_r      <= 1'b0;
        end else begin
            mem_en_r <= grant_s;
            mem_we_r <= grant_s & sel_we_s;
            busy_r   <= (state_nxt_s != ST_IDLE);
            if (grant_s) begin
                txn_we_r    <= sel_we_s;
                mem_addr_r  <= sel_addr_s;
                mem_wdata_r <= sel_wdata_s;
            end
            if (state_r == ST_ISSUE) begin
                lat_cnt_r <= LAT_LOAD;
            end else if (state_r == ST_WAIT) begin
                lat_cnt_r <= lat_cnt_r - 3'd1;
            end
        end
    end

    // Owner tracking and IF starvation counter (counts DM wins taken while IF waits).
    always_ff @(posedge clk1) begin
        if (reset) begin
            owner_r      <= PORT_NONE;
            starve_cnt_r <= {SC_W{1'b0}};
        end else begin
            if (grant_s) begin
                owner_r <= winner_s;
                if (winner_s == PORT_IF) begin
                    starve_cnt_r <= {SC_W{1'b0}};
                end else if ((winner_s == PORT_DM) && if_req && (starve_cnt_r != STARVE_LIM)) begin
                    starve_cnt_r <= starve_cnt_r + {{(SC_W-1){1'b0}}, 1'b1};
                end
            end else if (state_r == ST_RESP) begin
                owner_r <= PORT_NONE;
            end
        end
    end

    // Completion: read data capture on the final WAIT edge, one-cycle ack in RESP.
    always_ff @(posedge clk1) begin
        if (reset) begin
            if_ack_r    <= 1'b0;
            dm_ack_r    <= 1'b0;
            dbg_ack_r   <= 1'b0;
            if_rdata_r  <= {DATA_W{1'b0}};
            dm_rdata_r  <= {DATA_W{1'b0}};
            dbg_rdata_r <= {DATA_W{1'b0}};
        end else begin
            if_ack_r  <= done_s && (owner_r == PORT_IF);
            dm_ack_r  <= done_s && (owner_r == PORT_DM);
            dbg_ack_r <= done_s && (owner_r == PORT_DBG);
            if (done_s && !txn_we_r) begin
                case (owner_r)
                    PORT_IF:  if_rdata_r  <= mem_rdata;
                    PORT_DM:  dm_rdata_r  <= mem_rdata;
                    PORT_DBG: dbg_rdata_r <= mem_rdata;
                    default:  ;
                endcase
            end
        end
    end

    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign if_ack    = if_ack_r;
    assign dm_ack    = dm_ack_r;
    assign dbg_ack   = dbg_ack_r;
    assign if_rdata  = if_rdata_r;
    assign dm_rdata  = dm_rdata_r;
    assign dbg_rdata = dbg_rdata_r;
    assign owner     = owner_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected acks and grant owners are queued
// by the stimulus; a negedge monitor compares them as the DUT presents them.
// A second instance with MEM_LAT = 3 covers mid-transaction reset.
module tb_mem_port_arbiter;
    import mips32_mem_pkg::*;

    logic        clk1 = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we, dbg_req, dbg_we;
    logic [9:0]  if_addr, dm_addr, dbg_addr;
    logic [31:0] dm_wdata, dbg_wdata;
    logic        if_ack, dm_ack, dbg_ack, mem_en, mem_we, busy;
    logic [31:0] if_rdata, dm_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic [9:0]  mem_addr;
    logic [1:0]  owner;

    logic        reset3, dm_req3;
    logic [9:0]  dm_addr3, mem_addr3;
    logic        if_ack3, dm_ack3, dbg_ack3, mem_en3, mem_we3, busy3;
    logic [31:0] if_rdata3, dm_rdata3, dbg_rdata3, mem_wdata3, mem_rdata3;
    logic [1:0]  owner3;

    logic [31:0] mem  [0:1023];
    logic [31:0] mem3 [0:1023];
    logic [31:0] rd_a, rd3_a, rd3_b, rd3_c;

    typedef struct { logic [1:0] port; logic [31:0] data; } exp_t;
    exp_t       exp_q[$];
    logic [1:0] own_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_en_cyc = 0;

    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut (
        .clk1(clk1), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk1(clk1), .reset(reset3),
        .if_req(1'b0), .if_addr(10'd0), .if_ack(if_ack3), .if_rdata(if_rdata3),
        .dm_req(dm_req3), .dm_we(1'b0), .dm_addr(dm_addr3), .dm_wdata(32'd0),
        .dm_ack(dm_ack3), .dm_rdata(dm_rdata3),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(10'd0), .dbg_wdata(32'd0),
        .dbg_ack(dbg_ack3), .dbg_rdata(dbg_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .owner(owner3), .busy(busy3)
    );

    // Memory models: read data appears MEM_LAT cycles after the mem_en cycle.
    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            rd_a <= mem[mem_addr];
        end
        if (mem_en3) rd3_a <= mem3[mem_addr3];
        rd3_b <= rd3_a;
        rd3_c <= rd3_b;
    end
    assign mem_rdata  = rd_a;
    assign mem_rdata3 = rd3_c;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_txn(input logic [1:0] p, input logic [31:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        exp_q.push_back(e);
        own_q.push_back(p);
    endtask

    // Monitor: grant order at every mem strobe, port/data at every ack.
    always @(negedge clk1) begin : monitor
        int nack;
        exp_t e;
        logic [1:0] ap;
        logic [31:0] ad;
        if (mem_en) begin
            last_en_cyc = cyc;
            if (own_q.size() == 0) check("grant_unexpected", 32'(owner), 32'd3);
            else check("grant_owner", 32'(owner), 32'(own_q.pop_front()));
            if (owner == PORT_IF) check("if_grant_starve_clr", 32'(dut.starve_cnt_r), 32'd0);
        end
        nack = int'(if_ack) + int'(dm_ack) + int'(dbg_ack);
        if (nack != 0) begin
            check("single_ack", 32'(nack), 32'd1);
            ap = dbg_ack ? PORT_DBG : (dm_ack ? PORT_DM : PORT_IF);
            ad = dbg_ack ? dbg_rdata : (dm_ack ? dm_rdata : if_rdata);
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 32'(ap), 32'd3);
            end else begin
                e = exp_q.pop_front();
                check("ack_port", 32'(ap), 32'(e.port));
                check("ack_rdata", ad, e.data);
            end
        end
    end

    // Issue one request on port p and hold it until ack (bounded); keep leaves req high.
    task automatic port_req(input int p, input logic we, input logic [9:0] a,
                            input logic [31:0] wd, input bit keep, output int lat);
        int c0;
        bit got;
        c0 = cyc;
        got = 1'b0;
        lat = -1;
        case (p)
            0: begin if_req = 1'b1; if_addr = a; end
            1: begin dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd; end
            default: begin dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd; end
        endcase
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk1);
            if ((p == 0 && if_ack) || (p == 1 && dm_ack) || (p == 2 && dbg_ack)) got = 1'b1;
        end
        if (!got) check("ack_timeout", 32'(p), 32'hFFFF_FFFF);
        else lat = cyc - c0;
        @(posedge clk1); #1;
        if (!keep) begin
            case (p)
                0: if_req = 1'b0;
                1: dm_req = 1'b0;
                default: dbg_req = 1'b0;
            endcase
        end
    endtask

    task automatic wait_ack3(input int c0, output int lat);
        bit got;
        got = 1'b0;
        lat = -1;
        for (int i = 0; i < 32 && !got; i++) begin
            @(negedge clk1);
            if (dm_ack3) got = 1'b1;
        end
        if (!got) check("ack3_timeout", 32'd0, 32'd1);
        else lat = cyc - c0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int c0, la, lb, lc, n3;
        logic [1:0] o1, o4, o5;
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = 32'hA000_0000 + 32'(i);
            mem3[i] = 32'hB000_0000 + 32'(i);
        end
        mem[0] = 32'h2801_0078;
        if_req = 1'b0; if_addr = 10'd0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 10'd0; dm_wdata = 32'd0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 10'd0; dbg_wdata = 32'd0;
        dm_req3 = 1'b0; dm_addr3 = 10'd0;
        reset = 1'b1; reset3 = 1'b1;
        repeat (3) @(posedge clk1);
        #1 reset = 1'b0; reset3 = 1'b0;

        // Reset state
        @(negedge clk1);
        check("rst_owner", 32'(owner), 32'd3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobes", {28'd0, mem_en, mem_we, if_ack | dm_ack, dbg_ack}, 32'd0);
        check("rst_rdata", if_rdata | dm_rdata | dbg_rdata, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk1); #1;

        // 1: basic fetch, strobe in cycle 1, ack in cycle 3
        expect_txn(PORT_IF, 32'h2801_0078);
        c0 = cyc;
        port_req(0, 1'b0, 10'd0, 32'd0, 1'b0, la);
        check("t1_ack_latency", 32'(la), 32'd3);
        check("t1_mem_en_cycle", 32'(last_en_cyc - c0), 32'd1);

        // 2: debug store, DM load/store, debug read back; store leaves dm_rdata unchanged
        expect_txn(PORT_DBG, 32'd0);
        port_req(2, 1'b1, 10'd120, 32'd85, 1'b0, la);
        expect_txn(PORT_DM, 32'd85);
        port_req(1, 1'b0, 10'd120, 32'd0, 1'b0, la);
        expect_txn(PORT_DM, 32'd85);
        port_req(1, 1'b1, 10'd121, 32'd130, 1'b0, la);
        check("t2_store_latency", 32'(la), 32'd3);
        expect_txn(PORT_DBG, 32'd130);
        port_req(2, 1'b0, 10'd121, 32'd0, 1'b0, la);

        // 3: IF and DM together -> DM first (ack 3), IF next (ack 7), owner 1,3,0
        expect_txn(PORT_DM, 32'hA000_0006);
        expect_txn(PORT_IF, 32'hA000_0005);
        fork
            port_req(1, 1'b0, 10'd6, 32'd0, 1'b0, la);
            port_req(0, 1'b0, 10'd5, 32'd0, 1'b0, lb);
            begin
                @(negedge clk1); @(negedge clk1); o1 = owner;
                repeat (3) @(negedge clk1); o4 = owner;
                @(negedge clk1); o5 = owner;
            end
        join
        check("t3_dm_latency", 32'(la), 32'd3);
        check("t3_if_latency", 32'(lb), 32'd7);
        check("t3_owner_c1", 32'(o1), 32'd1);
        check("t3_owner_c4", 32'(o4), 32'd3);
        check("t3_owner_c5", 32'(o5), 32'd0);

        // 5: all three at once -> DBG, DM, IF
        expect_txn(PORT_DBG, 32'hA000_0007);
        expect_txn(PORT_DM,  32'hA000_0008);
        expect_txn(PORT_IF,  32'hA000_0009);
        fork
            port_req(2, 1'b0, 10'd7, 32'd0, 1'b0, la);
            port_req(1, 1'b0, 10'd8, 32'd0, 1'b0, lb);
            port_req(0, 1'b0, 10'd9, 32'd0, 1'b0, lc);
        join
        check("t5_dbg_latency", 32'(la), 32'd3);
        check("t5_dm_latency", 32'(lb), 32'd7);
        check("t5_if_latency", 32'(lc), 32'd11);

        // 4: sustained DM with IF pending -> 4 DM grants, forced IF, DM resumes
        for (int k = 0; k < 4; k++) expect_txn(PORT_DM, 32'hA000_0014 + 32'(k));
        expect_txn(PORT_IF, 32'hA000_000A);
        expect_txn(PORT_DM, 32'hA000_0018);
        expect_txn(PORT_DM, 32'hA000_0019);
        fork
            port_req(0, 1'b0, 10'd10, 32'd0, 1'b0, lc);
            for (int k = 0; k < 6; k++) port_req(1, 1'b0, 10'd20 + 10'(k), 32'd0, (k < 5), lb);
        join
        check("t4_if_latency", 32'(lc), 32'd19);
        check("t4_starve_cnt", 32'(dut.starve_cnt_r), 32'd0);
        check("t4_queue_drained", 32'(exp_q.size() + own_q.size()), 32'd0);

        // 6: MEM_LAT = 3 instance, reset in second WAIT cycle aborts without ack
        c0 = cyc;
        dm_req3 = 1'b1; dm_addr3 = 10'd31;
        wait_ack3(c0, la);
        check("t6_lat3_latency", 32'(la), 32'd5);
        check("t6_lat3_rdata", dm_rdata3, 32'hB000_001F);
        @(posedge clk1); #1 dm_req3 = 1'b0;
        @(posedge clk1); #1;
        c0 = cyc;
        dm_req3 = 1'b1; dm_addr3 = 10'd30;
        repeat (3) @(posedge clk1);
        #1 reset3 = 1'b1;
        @(negedge clk1);
        check("t6_in_wait_busy", 32'(busy3), 32'd1);
        @(posedge clk1);
        #1 reset3 = 1'b0; dm_req3 = 1'b0;
        @(negedge clk1);
        check("t6_post_rst_busy", 32'(busy3), 32'd0);
        check("t6_post_rst_owner", 32'(owner3), 32'd3);
        check("t6_post_rst_rdata", dm_rdata3, 32'd0);
        n3 = 0;
        repeat (8) begin
            @(negedge clk1);
            if (dm_ack3) n3++;
        end
        check("t6_no_ack_after_rst", 32'(n3), 32'd0);
        @(posedge clk1); #1;
        c0 = cyc;
        dm_req3 = 1'b1; dm_addr3 = 10'd30;
        wait_ack3(c0, la);
        check("t6_reissue_latency", 32'(la), 32'd5);
        check("t6_reissue_rdata", dm_rdata3, 32'hB000_001E);
        @(posedge clk1); #1 dm_req3 = 1'b0;

        repeat (4) @(posedge clk1);
        check("final_queues_empty", 32'(exp_q.size() + own_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
